// File: rtl/riscv_pkg.sv
// RISC-V load/store funct3 encodings shared by the data-memory blocks.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Number of bytes touched by an access; 0 marks a reserved encoding.
  function automatic logic [2:0] accessBytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      F3_W:        return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_ram_if.sv
// CPU MEM-stage data-memory bus: access request plus registered load result.
interface data_ram_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  write;
  logic                  read;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output address, data_in, write, read, funct3,
    input  data_out
  );

  modport slave (
    input  address, data_in, write, read, funct3,
    output data_out
  );

endinterface

// File: rtl/ram_byte_bank.sv
// One byte lane of the data memory: single write enable, registered read-first port.
module ram_byte_bank #(
  parameter int ROW_W = 14
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [ROW_W-1:0] row_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [0:(1<<ROW_W)-1];
  logic [7:0] rdata_q;

  // Both updates are non-blocking, so a same-edge read sees the old byte.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[row_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[row_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram.sv
// Byte-addressable little-endian RISC-V data memory: B/H/W stores, sign/zero-extended loads.
module data_ram
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  data_ram_if.slave bus
);

  localparam int ROW_W = ADDR_WIDTH - 2;

  logic [1:0]       laneOff;
  logic [ROW_W-1:0] addrRow;
  logic [2:0]       nBytes;
  logic [7:0]       laneRdata [4];

  assign laneOff = bus.address[1:0];
  assign addrRow = bus.address[ADDR_WIDTH-1:2];
  assign nBytes  = accessBytes(bus.funct3);

  // Lane l carries byte k = l - A[1:0]; lanes below the offset belong to the next row.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [1:0]       k;
    logic             carry;
    logic [ROW_W-1:0] row;
    logic             we;

    assign k     = 2'(l) - laneOff;
    assign carry = 2'(l) < laneOff;
    assign row   = addrRow + {{(ROW_W-1){1'b0}}, carry};
    assign we    = bus.write && !rst && ({1'b0, k} < nBytes);

    ram_byte_bank #(.ROW_W(ROW_W)) u_bank (
      .clk     (clk),
      .we_i    (we),
      .re_i    (bus.read),
      .row_i   (row),
      .wdata_i (bus.data_in[8*k +: 8]),
      .rdata_o (laneRdata[l])
    );
  end

  logic [1:0] loadOff_q, loadOff_d;
  logic [2:0] loadF3_q, loadF3_d;
  logic       zero_q, zero_d;

  always_comb begin
    loadOff_d = loadOff_q;
    loadF3_d  = loadF3_q;
    zero_d    = zero_q;
    if (bus.read) begin
      loadOff_d = laneOff;
      loadF3_d  = bus.funct3;
      zero_d    = (nBytes == 3'd0);
    end
  end

  // Load context is captured alongside the bank read so the result holds while read=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      loadOff_q <= 2'd0;
      loadF3_q  <= 3'd0;
      zero_q    <= 1'b1;
    end else begin
      loadOff_q <= loadOff_d;
      loadF3_q  <= loadF3_d;
      zero_q    <= zero_d;
    end
  end

  logic [DATA_WIDTH-1:0] loadWord;
  logic [DATA_WIDTH-1:0] loadResult;

  always_comb begin
    loadWord = '0;
    for (int k = 0; k < 4; k++) begin
      loadWord[8*k +: 8] = laneRdata[loadOff_q + 2'(k)];
    end
    case (loadF3_q)
      F3_B:    loadResult = {{24{loadWord[7]}}, loadWord[7:0]};
      F3_H:    loadResult = {{16{loadWord[15]}}, loadWord[15:0]};
      F3_W:    loadResult = loadWord;
      F3_BU:   loadResult = {24'd0, loadWord[7:0]};
      F3_HU:   loadResult = {16'd0, loadWord[15:0]};
      default: loadResult = '0;
    endcase
  end

  assign bus.data_out = zero_q ? '0 : loadResult;

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: directed stores/loads with hand-computed load results.
module tb_data_ram;

  typedef struct {
    string       name;
    logic [31:0] exp;
    int          due;
  } chk_t;

  logic clk;
  logic rst;
  int   cycle;
  int   checks;
  int   failures;
  chk_t sb[$];

  data_ram_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  data_ram #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input chk_t item);
    checks++;
    if (bus.data_out !== item.exp) begin
      failures++;
      $display("[TB] FAIL %s: data_out=%h expected=%h", item.name, bus.data_out, item.exp);
    end
  endtask

  // Monitor: pops every expectation due at this edge and compares it.
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0 && sb[0].due <= cycle) begin
      checkOutput(sb.pop_front());
    end
  end

  // One bus cycle; when chk is set the value data_out must show after the next edge is queued.
  task automatic applyStimulus(input logic [15:0] a, input logic [31:0] d,
                               input logic w, input logic r, input logic [2:0] f3,
                               input logic rs, input logic chk, input logic [31:0] exp,
                               input string nm);
    @(negedge clk);
    bus.address = a;
    bus.data_in = d;
    bus.write   = w;
    bus.read    = r;
    bus.funct3  = f3;
    rst         = rs;
    if (chk) sb.push_back('{name: nm, exp: exp, due: cycle + 1});
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    bus.address = '0;
    bus.data_in = '0;
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.funct3  = 3'b000;

    applyStimulus(16'h0000, 32'h0, 0, 0, 3'b010, 1, 1, 32'h00000000, "reset_state");

    // Byte store and signed/unsigned byte loads
    applyStimulus(16'hAAAA, 32'h000000A5, 1, 0, 3'b000, 0, 0, 32'h0, "sb");
    applyStimulus(16'hAAAA, 32'h0, 0, 1, 3'b000, 0, 1, 32'hFFFFFFA5, "lb_aaaa");
    applyStimulus(16'hAAAA, 32'h0, 0, 1, 3'b100, 0, 1, 32'h000000A5, "lbu_aaaa");

    // Misaligned halfword
    applyStimulus(16'hBBBB, 32'h00008123, 1, 0, 3'b001, 0, 0, 32'h0, "sh");
    applyStimulus(16'hBBBB, 32'h0, 0, 1, 3'b001, 0, 1, 32'hFFFF8123, "lh_bbbb");
    applyStimulus(16'hBBBB, 32'h0, 0, 1, 3'b101, 0, 1, 32'h00008123, "lhu_bbbb");
    applyStimulus(16'hBBBC, 32'h0, 0, 1, 3'b000, 0, 1, 32'hFFFFFF81, "lb_bbbc");

    // Word store, misaligned sub-word loads
    applyStimulus(16'h2222, 32'hDEADBEEF, 1, 0, 3'b010, 0, 0, 32'h0, "sw");
    applyStimulus(16'h2222, 32'h0, 0, 1, 3'b010, 0, 1, 32'hDEADBEEF, "lw_2222");
    applyStimulus(16'h2225, 32'h0, 0, 1, 3'b100, 0, 1, 32'h000000DE, "lbu_2225");
    applyStimulus(16'h2223, 32'h0, 0, 1, 3'b001, 0, 1, 32'hFFFFADBE, "lh_2223");

    // Address wrap-around
    applyStimulus(16'hFFFE, 32'h11223344, 1, 0, 3'b010, 0, 0, 32'h0, "sw_wrap");
    applyStimulus(16'hFFFE, 32'h0, 0, 1, 3'b010, 0, 1, 32'h11223344, "lw_fffe");
    applyStimulus(16'h0000, 32'h0, 0, 1, 3'b101, 0, 1, 32'h00001122, "lhu_0000");
    applyStimulus(16'hFFFF, 32'h0, 0, 1, 3'b000, 0, 1, 32'h00000033, "lb_ffff");
    applyStimulus(16'hFFFF, 32'h0000ABCD, 1, 0, 3'b001, 0, 0, 32'h0, "sh_wrap");
    applyStimulus(16'hFFFF, 32'h0, 0, 1, 3'b101, 0, 1, 32'h0000ABCD, "lhu_ffff");
    applyStimulus(16'hFFFE, 32'h0, 0, 1, 3'b010, 0, 1, 32'h11ABCD44, "lw_fffe_mix");

    // Same-edge load and store: read-first
    applyStimulus(16'h2222, 32'hCAFEF00D, 1, 1, 3'b010, 0, 1, 32'hDEADBEEF, "lw_sw_same_edge");
    applyStimulus(16'h2222, 32'h0, 0, 1, 3'b010, 0, 1, 32'hCAFEF00D, "lw_after_same_edge");

    // Reserved funct3: store ignored, load returns zero
    applyStimulus(16'h2222, 32'h12345678, 1, 0, 3'b011, 0, 0, 32'h0, "store_rsvd");
    applyStimulus(16'h2222, 32'h0, 0, 1, 3'b110, 0, 1, 32'h00000000, "load_rsvd");
    applyStimulus(16'h2222, 32'h0, 0, 1, 3'b010, 0, 1, 32'hCAFEF00D, "lw_after_rsvd_store");

    // BU encoding stores as a byte
    applyStimulus(16'h3001, 32'h000077FF, 1, 0, 3'b100, 0, 0, 32'h0, "sbu");
    applyStimulus(16'h3001, 32'h0, 0, 1, 3'b000, 0, 1, 32'hFFFFFFFF, "lb_3001");

    // Reset clears data_out and suppresses a concurrent store; read=0 holds
    applyStimulus(16'h2222, 32'h0, 0, 1, 3'b010, 0, 1, 32'hCAFEF00D, "lw_pre_reset");
    applyStimulus(16'h2222, 32'h55555555, 1, 0, 3'b010, 1, 1, 32'h00000000, "reset_clears");
    applyStimulus(16'h2222, 32'h0, 0, 0, 3'b010, 0, 1, 32'h00000000, "hold_after_reset");
    applyStimulus(16'h2222, 32'h0, 0, 1, 3'b010, 0, 1, 32'hCAFEF00D, "lw_store_in_reset_dropped");
    applyStimulus(16'hAAAA, 32'h0, 0, 0, 3'b000, 0, 1, 32'hCAFEF00D, "hold_read_low");
    applyStimulus(16'hBBBB, 32'h0, 0, 0, 3'b101, 0, 1, 32'hCAFEF00D, "hold_read_low_2");

    repeat (3) @(negedge clk);
    while (sb.size() > 0) begin
      chk_t item;
      item = sb.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL %s: expectation never checked, expected=%h", item.name, item.exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
